fc_io_controller: RTL
=====================

# fc_io_controller

Host-side counterpart of the `fc_layer` streaming interface. It holds one input vector loaded by the host and issues the `start` pulse to `fc_layer`. It serves `data_in` on every `input_req`, wrapping over the vector so the layer can re-read it per neuron, and captures each `out_valid` result into an output buffer the host reads back. It sits between the system/host bus and `fc_layer`, replacing the bench-driven feeder and collector.

## Interface
- `NUM_INPUTS`, 4, input vector length; input buffer depth.
- `NUM_NEURONS`, 10, expected outputs per run; output buffer depth.
- `IA_W`, 2, input buffer address width (≥ clog2(`NUM_INPUTS`)).
- `OA_W`, 4, output buffer address/count width (≥ clog2(`NUM_NEURONS`+1)).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_start` in 1: request a run; accepted only in IDLE or DONE.
- `load_we` in 1: write `load_data` to input buffer at `load_addr`; ignored while `busy`.
- `load_addr` in `IA_W`: input buffer address.
- `load_data` in 8: signed input element.
- `rd_addr` in `OA_W`: output buffer read address.
- `rd_data` out 8: registered read data, 1-cycle latency.
- `busy` out 1: high in START and RUN.
- `result_ready` out 1: high in DONE.
- `out_count` out `OA_W`: results captured this run.
- `overrun` out 1: sticky; more than `NUM_NEURONS` results arrived.
- `short_run` out 1: sticky; `fc_done` arrived with `out_count` < `NUM_NEURONS`.
- `fc_start` out 1: one-cycle start pulse to the layer.
- `fc_data_in` out 8: signed input element to the layer.
- `fc_input_req` in 1: layer requests the next input element.
- `fc_data_out` in 8: signed layer result.
- `fc_out_valid` in 1: `fc_data_out` valid this cycle.
- `fc_done` in 1: layer finished all neurons.

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE/DONE + `host_start` → START. On that edge:
  - input pointer `iptr` ← 0 and `out_count` ← 0.
  - `overrun` and `short_run` cleared.
- START, one cycle: `fc_start` = 1, then → RUN.
- RUN + `fc_done` → DONE. On that edge, `short_run` ← (`out_count` < `NUM_NEURONS`), using the count after any same-cycle capture.
- Input serving, in START and RUN, on each edge with `fc_input_req` = 1:
  - `fc_data_in` ← `ibuf[iptr]`.
  - `iptr` ← `iptr` = `NUM_INPUTS`-1 ? 0 : `iptr`+1.
- Outside START/RUN, `fc_input_req` is ignored; `fc_data_in` holds its value and `iptr` is unchanged.
- Capture, in RUN, on each edge with `fc_out_valid` = 1:
  - if `out_count` < `NUM_NEURONS`: `obuf[out_count]` ← `fc_data_out` and `out_count` increments.
  - otherwise the data is dropped, `overrun` ← 1, and `out_count` saturates.
- `fc_out_valid` outside RUN is ignored.
- Same-cycle `fc_out_valid` and `fc_done`: the result is captured, then → DONE.
- Host loads allowed in IDLE and DONE. `load_addr` ≥ `NUM_INPUTS` is ignored.
- `rd_data` ← `obuf[rd_addr]` every cycle. `rd_addr` ≥ `NUM_NEURONS` returns 0.
- Data is passed through unmodified: 8-bit signed, no arithmetic.

## Timing
- Reset values:
  - state IDLE.
  - `fc_start`, `busy`, `result_ready`, `overrun`, `short_run` = 0.
  - `fc_data_in` = 0, `rd_data` = 0, `out_count` = 0, `iptr` = 0.
  - Buffer contents are not reset.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values; `fc_start` is never re-issued.
- `host_start` at edge N → `fc_start` high during cycle N+1 → `busy` high from N+1.
- `fc_data_in` is valid the cycle after the edge that sampled `fc_input_req`, and holds until the next request. Back-to-back requests are served every cycle.
- `fc_done` sampled at edge M → `result_ready` = 1 and `busy` = 0 from M+1.
- `host_start` while `busy` is ignored.

## Test plan
- **Basic run:** load ibuf {0x01,0x02,0xFF,0x7F}, host_start, model layer issues 40 `input_req` and 10 `out_valid` with values 0x00..0x09, then `fc_done` → `fc_data_in` sequence is {01,02,FF,7F} repeated 10×, `out_count` = 10, `rd_data` at addr 3 = 0x03, `short_run` = 0, `overrun` = 0.
- **Start pulse and busy:** host_start pulsed → `fc_start` high exactly 1 cycle, 1 cycle after; `host_start` again while busy → no second `fc_start`.
- **Overrun:** 12 `out_valid` (0x10..0x1B) → `out_count` = 10, `overrun` = 1, addr 9 reads 0x19.
- **Short run and same-cycle done:** 7 `out_valid`, the 7th coincident with `fc_done` → `out_count` = 7, `short_run` = 1, addr 6 captured.
- **Restart:** second run with new ibuf {0x80,0,0,0x05} → `iptr` restarts at 0, first `fc_data_in` = 0x80, flags cleared.
- **Reset mid-RUN:** `rst_n` low after 5 requests → `busy` = 0, `fc_data_in` = 0 asynchronously; next run serves from element 0.

Source files
------------

// File: rtl/fc_io_controller_if.sv
// Streaming link between fc_io_controller and fc_layer.
// master: controller side (start, data_in out); slave: layer side.
interface fc_io_controller_if;
  logic       fc_start;
  logic [7:0] fc_data_in;
  logic       fc_input_req;
  logic [7:0] fc_data_out;
  logic       fc_out_valid;
  logic       fc_done;

  modport master (
    output fc_start,
    output fc_data_in,
    input  fc_input_req,
    input  fc_data_out,
    input  fc_out_valid,
    input  fc_done
  );

  modport slave (
    input  fc_start,
    input  fc_data_in,
    output fc_input_req,
    output fc_data_out,
    output fc_out_valid,
    output fc_done
  );
endinterface

// File: rtl/fc_io_controller.sv
// Host-side feeder/collector for fc_layer: input buffer, start, output buffer.
// Ports: clk, rst_n, host load/start/readback, status flags, fc link (master).
module fc_io_controller #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 10,
  parameter int IA_W        = 2,
  parameter int OA_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            host_start,
  input  logic            load_we,
  input  logic [IA_W-1:0] load_addr,
  input  logic [7:0]      load_data,
  input  logic [OA_W-1:0] rd_addr,
  output logic [7:0]      rd_data,
  output logic            busy,
  output logic            result_ready,
  output logic [OA_W-1:0] out_count,
  output logic            overrun,
  output logic            short_run,
  fc_io_controller_if.master fc
);

  typedef enum logic [1:0] {
    IDLE, START, RUN, DONE
  } state_t;

  localparam logic [IA_W-1:0] I_LAST =
    IA_W'(NUM_INPUTS - 1);
  localparam logic [OA_W-1:0] N_MAX =
    OA_W'(NUM_NEURONS);

  state_t state, state_nx;

  logic [7:0] ibuf [NUM_INPUTS];
  logic [7:0] obuf [NUM_NEURONS];

  logic [IA_W-1:0] iptr;
  logic [7:0]      data_q;
  logic            start_o;
  logic            accept, serve, in_run;
  logic            full, cap, drop;
  logic [OA_W-1:0] cnt_nx;

  assign accept = host_start &&
    (state == IDLE || state == DONE);
  assign in_run = (state == RUN);
  assign serve  = fc.fc_input_req &&
    (state == START || state == RUN);
  assign full   = !(out_count < N_MAX);
  assign cap    = in_run && fc.fc_out_valid && !full;
  assign drop   = in_run && fc.fc_out_valid && full;
  // count as it will be after this edge's capture
  assign cnt_nx = cap ? out_count + OA_W'(1)
                      : out_count;

  assign fc.fc_start   = start_o;
  assign fc.fc_data_in = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = START;
      START: state_nx = RUN;
      RUN:   if (fc.fc_done) state_nx = DONE;
      DONE:  if (accept) state_nx = START;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_o      = 1'b0;
    busy         = 1'b0;
    result_ready = 1'b0;
    unique case (state)
      START: begin
        start_o = 1'b1;
        busy    = 1'b1;
      end
      RUN:   busy = 1'b1;
      DONE:  result_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iptr      <= '0;
      data_q    <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
      short_run <= 1'b0;
    end else if (accept) begin
      iptr      <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
      short_run <= 1'b0;
    end else begin
      if (serve) begin
        data_q <= ibuf[iptr];
        iptr   <= (iptr == I_LAST) ? '0
                  : iptr + IA_W'(1);
      end
      out_count <= cnt_nx;
      if (drop) overrun <= 1'b1;
      if (in_run && fc.fc_done)
        short_run <= (cnt_nx < N_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (32'(rd_addr) < NUM_NEURONS)
      rd_data <= obuf[rd_addr];
    else
      rd_data <= '0;
  end

  // buffer contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (load_we && !busy &&
        32'(load_addr) < NUM_INPUTS)
      ibuf[load_addr] <= load_data;
    if (cap)
      obuf[out_count] <= fc.fc_data_out;
  end

endmodule
